// File: rtl/mem_arb_pkg.sv
// Shared types and lane helpers for the core memory-port arbiter.
// Lane i of a byte_lanes_t carries word bits [8i+7:8i].
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef logic [3:0][7:0] byte_lanes_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    function automatic byte_lanes_t pack_lanes(input logic [31:0] word);
        byte_lanes_t lanes;
        for (int i = 0; i < 4; i++) begin
            lanes[i] = word[8*i +: 8];
        end
        return lanes;
    endfunction

    function automatic logic [31:0] unpack_lanes(input byte_lanes_t lanes);
        logic [31:0] word;
        for (int i = 0; i < 4; i++) begin
            word[8*i +: 8] = lanes[i];
        end
        return word;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Requester selection: load/store wins contested cycles until the streak
// counter reaches DATA_STREAK_MAX, at which point fetch is forced through.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_STREAK_MAX = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    if_valid,
    input  logic    d_valid,
    input  logic    fire,
    output req_id_t sel
);

    localparam logic [3:0] StreakMax = 4'(DATA_STREAK_MAX);

    logic [3:0] streak_q, streak_d;

    always_comb begin
        sel = REQ_IF;
        if (d_valid && !(if_valid && (streak_q == StreakMax))) begin
            sel = REQ_D;
        end
    end

    // Only contested data grants count toward starving fetch.
    always_comb begin
        streak_d = streak_q;
        if (fire) begin
            if (sel == REQ_IF) begin
                streak_d = '0;
            end else if (if_valid && (streak_q < StreakMax)) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency byte-lane memory port between instruction fetch
// and load/store, one access at a time, with a response pulse per access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned DATA_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_we,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic [31:0] mem_addr,
    output byte_lanes_t mem_data_in,
    output logic        mem_write_en,
    input  byte_lanes_t mem_data_out,
    output logic        busy
);

    localparam logic [1:0] CntLoad = 2'(MEM_LATENCY - 1);

    arb_state_t  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [29:0] waddr_q, waddr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_q, rsp_d;
    req_id_t     id_q, id_d;

    req_id_t     sel;
    logic        grant_ok;
    logic        fire;
    logic        in_resp;
    logic        unused_addr_bits;

    // Byte offset within the word is deliberately dropped.
    assign unused_addr_bits = ^{if_req_addr[1:0], d_req_addr[1:0]};

    mem_arb_prio #(
        .DATA_STREAK_MAX(DATA_STREAK_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .if_valid(if_req_valid),
        .d_valid (d_req_valid),
        .fire    (fire),
        .sel     (sel)
    );

    // Readies are gated by rst so nothing is accepted while reset is held.
    assign grant_ok     = (state_q == IDLE) && !halt && !rst;
    assign if_req_ready = grant_ok && if_req_valid && (sel == REQ_IF);
    assign d_req_ready  = grant_ok && d_req_valid && (sel == REQ_D);
    assign fire         = if_req_ready || d_req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rsp_d   = rsp_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = ACCESS;
                    cnt_d   = CntLoad;
                    id_d    = sel;
                    if (sel == REQ_D) begin
                        waddr_d = d_req_addr[31:2];
                        we_d    = d_req_we;
                        wdata_d = d_req_wdata;
                    end else begin
                        waddr_d = if_req_addr[31:2];
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 2'd0) begin
                    rsp_d   = we_q ? 32'h0 : unpack_lanes(mem_data_out);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rsp_q   <= '0;
            id_q    <= REQ_IF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
            id_q    <= id_d;
        end
    end

    // The counter still holds its load value only in the first ACCESS cycle.
    always_comb begin
        mem_addr     = '0;
        mem_data_in  = '0;
        mem_write_en = 1'b0;
        if (state_q == ACCESS) begin
            mem_addr     = {waddr_q, 2'b00};
            mem_data_in  = pack_lanes(wdata_q);
            mem_write_en = we_q && (cnt_q == CntLoad);
        end
    end

    assign busy         = (state_q != IDLE);
    assign in_resp      = (state_q == RESP);
    assign if_rsp_valid = in_resp && (id_q == REQ_IF);
    assign d_rsp_valid  = in_resp && (id_q == REQ_D);
    assign if_rsp_data  = if_rsp_valid ? rsp_q : 32'h0;
    assign d_rsp_data   = d_rsp_valid ? rsp_q : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at latency 2 for the main scenarios and one at
// latency 1 for back-to-back fetch, both sharing a small word memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        halt, if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data, mem_addr;
    byte_lanes_t mem_data_in, mem_data_out;
    logic        mem_write_en, busy;

    logic        halt1, if_valid1, if_ready1, if_rsp_valid1;
    logic [31:0] if_addr1, if_rsp_data1;
    logic        d_valid1, d_ready1, d_we1, d_rsp_valid1;
    logic [31:0] d_addr1, d_wdata1, d_rsp_data1, mem_addr1;
    byte_lanes_t mem_data_in1, mem_data_out1;
    logic        mem_write_en1, busy1;

    logic [31:0] mem [0:63] = '{16: 32'h11223344, 32: 32'hCAFEF00D, default: 32'h0};

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[7:2]] <= mem_data_in;
    end
    assign mem_data_out  = mem[mem_addr[7:2]];
    assign mem_data_out1 = mem[mem_addr1[7:2]];

    mem_port_arbiter #(.MEM_LATENCY(2), .DATA_STREAK_MAX(4)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .DATA_STREAK_MAX(4)) dut1 (
        .clk(clk), .rst(rst), .halt(halt1),
        .if_req_valid(if_valid1), .if_req_ready(if_ready1), .if_req_addr(if_addr1),
        .if_rsp_valid(if_rsp_valid1), .if_rsp_data(if_rsp_data1),
        .d_req_valid(d_valid1), .d_req_ready(d_ready1), .d_req_addr(d_addr1),
        .d_req_we(d_we1), .d_req_wdata(d_wdata1),
        .d_rsp_valid(d_rsp_valid1), .d_rsp_data(d_rsp_data1),
        .mem_addr(mem_addr1), .mem_data_in(mem_data_in1), .mem_write_en(mem_write_en1),
        .mem_data_out(mem_data_out1), .busy(busy1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] exp_d;

    initial begin
        rst = 1'b1; halt = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h80;
        d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_we = 1'b0; d_req_wdata = '0;
        halt1 = 1'b0; if_valid1 = 1'b0; if_addr1 = '0;
        d_valid1 = 1'b0; d_addr1 = '0; d_we1 = 1'b0; d_wdata1 = '0;
        exp_d = 10'b0111101111;

        // Reset: readies forced low even with both requests valid
        tick(); tick();
        check("rst_d_ready", {31'b0, d_req_ready}, 32'd0);
        check("rst_if_ready", {31'b0, if_req_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rsp", {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
        if_req_valid = 1'b0; d_req_valid = 1'b0; rst = 1'b0;
        tick();

        // Single load from 0x40
        d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_we = 1'b0;
        #1;
        check("ld_ready", {31'b0, d_req_ready}, 32'd1);
        check("ld_if_ready", {31'b0, if_req_ready}, 32'd0);
        tick(); d_req_valid = 1'b0;
        check("ld_busy", {31'b0, busy}, 32'd1);
        check("ld_addr1", mem_addr, 32'h40);
        check("ld_we", {31'b0, mem_write_en}, 32'd0);
        check("ld_ready_acc", {31'b0, d_req_ready}, 32'd0);
        tick();
        check("ld_addr2", mem_addr, 32'h40);
        check("ld_norsp", {31'b0, d_rsp_valid}, 32'd0);
        tick();
        check("ld_rsp", {31'b0, d_rsp_valid}, 32'd1);
        check("ld_data", d_rsp_data, 32'h11223344);
        check("ld_if_rsp", {31'b0, if_rsp_valid}, 32'd0);
        tick();
        check("ld_rsp_end", {31'b0, d_rsp_valid}, 32'd0);
        check("ld_idle", {31'b0, busy}, 32'd0);

        // Store to unaligned 0x43 lands at word 0x40
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h43; d_req_wdata = 32'hAABBCCDD;
        #1;
        check("st_ready", {31'b0, d_req_ready}, 32'd1);
        tick(); d_req_valid = 1'b0; d_req_we = 1'b0;
        check("st_addr", mem_addr, 32'h40);
        check("st_lanes", mem_data_in, 32'hAABBCCDD);
        check("st_lane0", {24'b0, mem_data_in[0]}, 32'hDD);
        check("st_lane3", {24'b0, mem_data_in[3]}, 32'hAA);
        check("st_we1", {31'b0, mem_write_en}, 32'd1);
        tick();
        check("st_we2", {31'b0, mem_write_en}, 32'd0);
        tick();
        check("st_rsp", {31'b0, d_rsp_valid}, 32'd1);
        check("st_rsp_data", d_rsp_data, 32'd0);
        tick();
        check("st_mem", mem[16], 32'hAABBCCDD);

        // Starvation bound: D,D,D,D,IF,D,D,D,D,IF
        if_req_valid = 1'b1; if_req_addr = 32'h80;
        d_req_valid = 1'b1; d_req_addr = 32'h40;
        #1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("grant%0d_d", i), {31'b0, d_req_ready}, {31'b0, exp_d[i]});
            check($sformatf("grant%0d_if", i), {31'b0, if_req_ready}, {31'b0, !exp_d[i]});
            tick(); tick(); tick();
            if (exp_d[i]) begin
                check($sformatf("grant%0d_drsp", i), {31'b0, d_rsp_valid}, 32'd1);
            end else begin
                check($sformatf("grant%0d_ifrsp", i), {31'b0, if_rsp_valid}, 32'd1);
                check($sformatf("grant%0d_ifdata", i), if_rsp_data, 32'hCAFEF00D);
            end
            tick();
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        tick();

        // Halt raised one cycle after a fetch handshake
        if_req_valid = 1'b1;
        #1;
        check("h_ready", {31'b0, if_req_ready}, 32'd1);
        tick(); halt = 1'b1;
        check("h_busy", {31'b0, busy}, 32'd1);
        tick(); tick();
        check("h_rsp", {31'b0, if_rsp_valid}, 32'd1);
        check("h_data", if_rsp_data, 32'hCAFEF00D);
        tick();
        check("h_blk1", {31'b0, if_req_ready}, 32'd0);
        check("h_idle", {31'b0, busy}, 32'd0);
        tick();
        check("h_blk2", {31'b0, if_req_ready}, 32'd0);
        halt = 1'b0;
        #1;
        check("h_resume", {31'b0, if_req_ready}, 32'd1);
        tick(); if_req_valid = 1'b0;
        check("h_resume_busy", {31'b0, busy}, 32'd1);
        tick(); tick(); tick();

        // Reset in the second ACCESS cycle drops the access
        d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_we = 1'b0;
        #1;
        check("r_ready", {31'b0, d_req_ready}, 32'd1);
        tick(); d_req_valid = 1'b0;
        tick();
        check("r_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("r_busy", {31'b0, busy}, 32'd0);
        check("r_addr", mem_addr, 32'd0);
        check("r_we", {31'b0, mem_write_en}, 32'd0);
        tick();
        check("r_norsp", {31'b0, d_rsp_valid}, 32'd0);
        rst = 1'b0; d_req_valid = 1'b1;
        #1;
        check("r_regrant", {31'b0, d_req_ready}, 32'd1);
        tick(); d_req_valid = 1'b0;
        tick(); tick();
        check("r_rsp", {31'b0, d_rsp_valid}, 32'd1);
        check("r_data", d_rsp_data, 32'hAABBCCDD);
        tick();

        // Latency-1 pass-through: fetch accepted every third cycle
        if_valid1 = 1'b1; if_addr1 = 32'h80;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pt%0d_ready", i), {31'b0, if_ready1}, 32'd1);
            check($sformatf("pt%0d_dready", i), {31'b0, d_ready1}, 32'd0);
            tick();
            check($sformatf("pt%0d_busy", i), {31'b0, busy1}, 32'd1);
            check($sformatf("pt%0d_norsp", i), {31'b0, if_rsp_valid1}, 32'd0);
            check($sformatf("pt%0d_we", i), {31'b0, mem_write_en1}, 32'd0);
            check($sformatf("pt%0d_lanes", i), mem_data_in1, 32'd0);
            tick();
            check($sformatf("pt%0d_rsp", i), {31'b0, if_rsp_valid1}, 32'd1);
            check($sformatf("pt%0d_data", i), if_rsp_data1, 32'hCAFEF00D);
            check($sformatf("pt%0d_drsp", i), {d_rsp_data1[31:1], d_rsp_valid1}, 32'd0);
            tick();
        end
        if_valid1 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
